// File: rtl/hdmi_cfg_sequencer.sv
// HDMI transmitter configuration sequencer: writes an external register table over
// AXI4-Lite, then polls a status register until its ready bit sets. A lost hot-plug
// restarts the table after the in-flight transaction; a stalled handshake aborts.
module hdmi_cfg_sequencer #(
  parameter int unsigned N_WRITES  = 8,
  parameter logic [7:0]  POLL_ADDR = 8'h04,
  parameter int unsigned POLL_MAX  = 16,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        axi_clk,
  input  logic        axi_resetn,
  input  logic        start,
  input  logic        hpd_in,
  output logic [7:0]  tbl_idx,
  input  logic [7:0]  tbl_addr,
  input  logic [31:0] tbl_data,
  output logic [7:0]  m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [7:0]  m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam logic [7:0]  LastIdx    = 8'(N_WRITES - 1);
  localparam logic [7:0]  PollMax    = 8'(POLL_MAX);
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StWaitHpd, StWrReq, StWrResp, StRdReq, StRdResp, StDone, StErr
  } state_e;

  state_e      state_q;
  logic        hpd_meta_q, hpd_s_q, hpd_lost_q;
  logic [7:0]  idx_q, awaddr_q, araddr_q, poll_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        issued_q, aw_ok_q, w_ok_q;
  logic        busy_q, done_q, error_q;
  logic [1:0]  err_q;
  logic [15:0] wdog_q;
  logic        active, hpd_gone, aw_acc, w_acc, timeout;
  logic        unused_rdata;

  assign active   = state_q inside {StWrReq, StWrResp, StRdReq, StRdResp};
  // HPD loss is remembered so a short glitch mid-transaction still forces a restart.
  assign hpd_gone = hpd_lost_q | ~hpd_s_q;
  assign aw_acc   = awvalid_q & m_awready;
  assign w_acc    = wvalid_q & m_wready;
  assign timeout  = active && (wdog_q == TimeoutVal);
  assign unused_rdata = ^m_rdata[31:1];

  // Two-flop synchroniser for the asynchronous hot-plug detect.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      hpd_meta_q <= 1'b0;
      hpd_s_q    <= 1'b0;
    end else begin
      hpd_meta_q <= hpd_in;
      hpd_s_q    <= hpd_meta_q;
    end
  end

  // Sequencer FSM with registered AXI and status outputs.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= StIdle;
      hpd_lost_q <= 1'b0;
      idx_q      <= '0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      poll_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      issued_q   <= 1'b0;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= '0;
      wdog_q     <= '0;
    end else begin
      wdog_q <= active ? wdog_q + 16'd1 : '0;
      if (active && !hpd_s_q) hpd_lost_q <= 1'b1;
      if (timeout) begin
        state_q   <= StErr;
        err_q     <= 2'b11;
        error_q   <= 1'b1;
        busy_q    <= 1'b0;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        issued_q  <= 1'b0;
        wdog_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle, StDone, StErr: if (start) begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= '0;
            idx_q      <= '0;
            poll_q     <= '0;
            hpd_lost_q <= 1'b0;
            issued_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= hpd_s_q ? StWrReq : StWaitHpd;
          end
          StWaitHpd: if (hpd_s_q) begin
            hpd_lost_q <= 1'b0;
            issued_q   <= 1'b0;
            state_q    <= StWrReq;
          end
          StWrReq: begin
            // First cycle latches the table entry once tbl_idx has settled.
            if (!issued_q) begin
              awaddr_q  <= tbl_addr;
              wdata_q   <= tbl_data;
              wstrb_q   <= 4'hF;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_ok_q   <= 1'b0;
              w_ok_q    <= 1'b0;
              issued_q  <= 1'b1;
            end else begin
              if (aw_acc) begin
                awvalid_q <= 1'b0;
                aw_ok_q   <= 1'b1;
              end
              if (w_acc) begin
                wvalid_q <= 1'b0;
                w_ok_q   <= 1'b1;
              end
              if ((aw_ok_q | aw_acc) && (w_ok_q | w_acc)) begin
                issued_q <= 1'b0;
                bready_q <= 1'b1;
                wdog_q   <= '0;
                state_q  <= StWrResp;
              end
            end
          end
          StWrResp: if (m_bvalid) begin
            bready_q <= 1'b0;
            wdog_q   <= '0;
            if (m_bresp != 2'b00) begin
              err_q   <= 2'b01;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StErr;
            end else if (hpd_gone) begin
              idx_q      <= '0;
              hpd_lost_q <= 1'b0;
              state_q    <= StWaitHpd;
            end else if (idx_q == LastIdx) begin
              poll_q    <= '0;
              araddr_q  <= POLL_ADDR;
              arvalid_q <= 1'b1;
              state_q   <= StRdReq;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= StWrReq;
            end
          end
          StRdReq: if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            wdog_q    <= '0;
            state_q   <= StRdResp;
          end
          StRdResp: if (m_rvalid) begin
            rready_q <= 1'b0;
            wdog_q   <= '0;
            if (m_rresp != 2'b00) begin
              err_q   <= 2'b01;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StErr;
            end else if (hpd_gone) begin
              idx_q      <= '0;
              hpd_lost_q <= 1'b0;
              state_q    <= StWaitHpd;
            end else if (m_rdata[0]) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else if (poll_q + 8'd1 == PollMax) begin
              poll_q  <= poll_q + 8'd1;
              err_q   <= 2'b10;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StErr;
            end else begin
              poll_q    <= poll_q + 8'd1;
              arvalid_q <= 1'b1;
              state_q   <= StRdReq;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tbl_idx   = idx_q;
  assign m_awaddr  = awaddr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = araddr_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_q;

endmodule
